// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the asynchronous FIFO and the UART transmitter.
// master = the consumer that pops; slave = the FIFO read side.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  buf_empty;

  modport master (output rd_en, input buf_out, input buf_empty);
  modport slave  (input rd_en, output buf_out, output buf_empty);
endinterface

// File: rtl/fifo_uart_tx.sv
// Read-domain UART transmitter: pops bytes from the FIFO one at a time and shifts them
// out LSB first with one start bit and STOP_BITS stop bits, CLKS_PER_BIT clocks per bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk_r,
  input  logic                rst,
  input  logic                tx_en,
  fifo_uart_tx_if.master      fifo,
  output logic                tx,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [BAUD_W-1:0]     baud, baud_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  cnt_inc;
  logic                  tx_nxt;
  logic                  baud_end;
  logic                  can_fetch;

  assign baud_end  = (baud == BAUD_LAST);
  assign can_fetch = tx_en && !fifo.buf_empty;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    idx_nxt   = idx;
    shift_nxt = shift;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (can_fetch) state_nxt = FETCH;
      end
      FETCH: begin
        state_nxt = LOAD;
      end
      LOAD: begin
        // buf_out is valid here, one cycle after the rd_en pulse.
        shift_nxt = fifo.buf_out;
        baud_nxt  = '0;
        idx_nxt   = '0;
        state_nxt = START;
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (idx == DATA_LAST) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else begin
            idx_nxt   = idx + 1'b1;
            shift_nxt = shift >> 1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      STOP: begin
        // idx is reused to count stop bits.
        if (baud_end) begin
          baud_nxt = '0;
          if (idx == STOP_LAST) begin
            idx_nxt   = '0;
            cnt_inc   = 1'b1;
            state_nxt = can_fetch ? FETCH : IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // tx and rd_en are registered from the next state so both line up with the state register.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      idx       <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      fifo.rd_en <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      state      <= state_nxt;
      baud       <= baud_nxt;
      idx        <= idx_nxt;
      shift      <= shift_nxt;
      tx         <= tx_nxt;
      fifo.rd_en <= (state_nxt == FETCH);
      if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and randomized bench for fifo_uart_tx: two instances (1 and 2 stop bits), each fed
// by a 1-cycle-latency FIFO model; frames are compared with a bit-slot reference model.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        tx1, busy1, tx2, busy2;
  logic [15:0] cnt1, cnt2;
  logic        sel = 1'b0;
  logic        txs;

  int checks = 0;
  int failures = 0;
  int rd1 = 0, rd2 = 0, bad1 = 0, bad2 = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) f1 ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) f2 ();

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk_r(clk), .rst(rst), .tx_en(tx_en), .fifo(f1.master),
    .tx(tx1), .busy(busy1), .frame_cnt(cnt1));

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk_r(clk), .rst(rst), .tx_en(tx_en), .fifo(f2.master),
    .tx(tx2), .busy(busy2), .frame_cnt(cnt2));

  assign txs = sel ? tx2 : tx1;

  // FIFO models: written only by the bench (wr) and the pop process (rd).
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic [7:0] wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;
  assign f1.buf_empty = (wp1 == rp1);
  assign f2.buf_empty = (wp2 == rp2);

  always @(posedge clk) begin
    if (f1.rd_en && !f1.buf_empty) begin
      f1.buf_out <= mem1[rp1];
      rp1 <= rp1 + 8'd1;
    end
    if (f2.rd_en && !f2.buf_empty) begin
      f2.buf_out <= mem2[rp2];
      rp2 <= rp2 + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (f1.rd_en) rd1 <= rd1 + 1;
    if (f2.rd_en) rd2 <= rd2 + 1;
    if (f1.rd_en && f1.buf_empty) bad1 <= bad1 + 1;
    if (f2.rd_en && f2.buf_empty) bad2 <= bad2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit which, input logic [7:0] b);
    if (which) begin mem2[wp2] = b; wp2 = wp2 + 8'd1; end
    else       begin mem1[wp1] = b; wp1 = wp1 + 8'd1; end
  endtask

  // Reference: slot 0 start (0), slots 1..8 data LSB first, remaining slots stop (1).
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int k;
    k = i / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Waits for the start bit (bounded), then records the whole frame one sample per clock.
  // Returns at the negedge of the last stop cycle.
  task automatic check_frame(input string tag, input logic [7:0] b, input int sb,
                             input int drop_at);
    int n;
    int len;
    logic [63:0] obs, expv;
    logic [7:0] dec;
    len = (1 + 8 + sb) * CPB;
    n = 0;
    while (txs !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lead"}, n, 3);
    obs = '0;
    expv = '0;
    for (int i = 0; i < len; i++) begin
      obs[i]  = txs;
      expv[i] = exp_bit(b, i);
      if (i == drop_at) tx_en = 1'b0;
      if (i < len - 1) @(negedge clk);
    end
    check({tag, "_wave_lo"}, obs[31:0], expv[31:0]);
    check({tag, "_wave_hi"}, obs[63:32], expv[63:32]);
    for (int k = 0; k < 8; k++) dec[k] = obs[(k + 1) * CPB + CPB / 2];
    check({tag, "_byte"}, dec, b);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    logic [7:0] rb [6];

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold", {tx1, f1.rd_en, busy1, cnt1}, {1'b1, 1'b0, 1'b0, 16'h0000});
    end
    rst = 1'b0;
    tx_en = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("reset_idle", {tx1, busy1, f1.rd_en}, {1'b1, 1'b0, 1'b0});
    check("reset_no_rd", rd1, 0);

    // Single byte.
    @(negedge clk);
    base = rd1;
    push(1'b0, 8'hAA);
    check_frame("single", 8'hAA, 1, -1);
    @(negedge clk); #1;
    check("single_cnt", cnt1, 1);
    check("single_busy", busy1, 0);
    check("single_rd", rd1 - base, 1);

    // Three queued bytes, back to back.
    pulse_reset();
    base = rd1;
    push(1'b0, 8'hAA); push(1'b0, 8'hBB); push(1'b0, 8'hCC);
    check_frame("b2b0", 8'hAA, 1, -1);
    check_frame("b2b1", 8'hBB, 1, -1);
    check_frame("b2b2", 8'hCC, 1, -1);
    repeat (5) @(negedge clk); #1;
    check("b2b_cnt", cnt1, 3);
    check("b2b_rd", rd1 - base, 3);
    check("b2b_busy", busy1, 0);

    // tx_en dropped during the data bits of the second frame.
    pulse_reset();
    base = rd1;
    push(1'b0, 8'hAA); push(1'b0, 8'hBB); push(1'b0, 8'hCC);
    check_frame("en0", 8'hAA, 1, -1);
    check_frame("en1", 8'hBB, 1, 3 * CPB);
    repeat (12) @(negedge clk); #1;
    check("en_hold_cnt", cnt1, 2);
    check("en_hold_rd", rd1 - base, 2);
    check("en_hold_idle", {busy1, tx1}, {1'b0, 1'b1});
    @(negedge clk);
    tx_en = 1'b1;
    check_frame("en2", 8'hCC, 1, -1);
    @(negedge clk); #1;
    check("en_cnt", cnt1, 3);
    check("en_rd", rd1 - base, 3);

    // Reset during data bit 3 aborts the frame.
    pulse_reset();
    push(1'b0, 8'h3C); push(1'b0, 8'h0F);
    check_frame("ab0", 8'h3C, 1, -1);
    repeat (3) @(negedge clk);
    repeat ((1 + 3) * CPB + 1) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_tx", tx1, 1);
    check("abort_busy", busy1, 0);
    check("abort_cnt", cnt1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(1'b0, 8'hE7);
    check_frame("ab1", 8'hE7, 1, -1);
    @(negedge clk); #1;
    check("abort_after_cnt", cnt1, 1);

    // Two stop bits and frame counter wrap on the second instance.
    sel = 1'b1;
    force dut2.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut2.frame_cnt;
    @(negedge clk);
    check("wrap_pre", cnt2, 16'hFFFF);
    base = rd2;
    push(1'b1, 8'h55);
    check_frame("stop2", 8'h55, 2, -1);
    @(negedge clk); #1;
    check("wrap_cnt", cnt2, 16'h0000);
    check("stop2_rd", rd2 - base, 1);
    check("stop2_busy", busy2, 0);
    sel = 1'b0;

    // Randomized bytes, one burst then a second burst after idle.
    pulse_reset();
    base = rd1;
    for (int i = 0; i < 6; i++) rb[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) push(1'b0, rb[i]);
    for (int i = 0; i < 3; i++) check_frame("rnd", rb[i], 1, -1);
    repeat (3 + $urandom_range(0, 6)) @(negedge clk);
    for (int i = 3; i < 6; i++) push(1'b0, rb[i]);
    for (int i = 3; i < 6; i++) check_frame("rnd", rb[i], 1, -1);
    @(negedge clk); #1;
    check("rnd_cnt", cnt1, 6);
    check("rnd_rd", rd1 - base, 6);
    check("rd_while_empty", bad1 + bad2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
